// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   UART transmitter fed by a small circular FIFO. The CPU pushes bytes with
//   uart_sel & wr. Queued bytes are serialised LSB first as a start bit, the
//   data bits, an optional parity bit and the stop bits. Frames run back to
//   back while the FIFO holds data.
//
//   Optional feature: define UART_TX_PARITY_EN to add a parity bit to every
//   frame. PARITY_ODD then selects odd (1) or even (0) parity.
//
//   Ports
//     clk        : rising-edge clock
//     rst        : asynchronous active-low reset
//     uart_sel   : address decode select
//     wr         : write strobe (push = uart_sel & wr)
//     data_in    : write data; bits above DATA_BITS-1 are ignored
//     tx         : registered serial output, idles high
//     busy       : transmitter is not idle
//     fifo_full  : FIFO holds FIFO_DEPTH entries
//     fifo_empty : FIFO holds no entries
//     fifo_count : FIFO occupancy
//     overflow   : sticky; a push was dropped because the FIFO was full
//
//   state  | meaning
//   IDLE   | line high, waiting for the FIFO to hold data
//   START  | start bit (low)
//   DATA   | data bits, LSB first
//   PARITY | parity bit (UART_TX_PARITY_EN only)
//   STOP   | stop bit(s); pops the next byte straight into START if present
module uart_tx_fifo #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4,
    parameter int STOP_BITS    = 1
`ifdef UART_TX_PARITY_EN
    ,
    parameter int PARITY_ODD   = 0
`endif
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        uart_sel,
    input  logic                        wr,
    input  logic [7:0]                  data_in,
    output logic                        tx,
    output logic                        busy,
    output logic                        fifo_full,
    output logic                        fifo_empty,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        overflow
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(CLKS_PER_BIT);

    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic [PW:0]   DEPTH_C   = (PW + 1)'(FIFO_DEPTH);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] ST_PARITY = 3'd3;
`endif
    localparam logic [2:0] ST_STOP   = 3'd4;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [PW:0]          count;

    logic [2:0]           state;
    logic [BW-1:0]        baud_cnt;
    logic [2:0]           bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;

    logic push;
    logic pop;
    logic bit_end;
    logic last_stop;

`ifdef UART_TX_PARITY_EN
    logic parity_bit;
    logic parity_next;
    assign parity_next = (^mem[rd_ptr]) ^ 1'(PARITY_ODD);
`endif

    assign fifo_count = count;
    assign fifo_full  = (count == DEPTH_C);
    assign fifo_empty = (count == '0);
    assign busy       = (state != ST_IDLE);

    assign push      = uart_sel & wr & ~fifo_full;
    assign bit_end   = (baud_cnt == BAUD_LAST);
    assign last_stop = (state == ST_STOP) & bit_end & (bit_cnt == STOP_LAST);
    // fifo_empty is the registered occupancy, so a byte pushed this cycle
    // cannot be popped until the next one.
    assign pop       = ~fifo_empty & ((state == ST_IDLE) | last_stop);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data_in[DATA_BITS-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (uart_sel && wr && fifo_full) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            tx        <= 1'b1;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;
            case (state)
                ST_IDLE: begin
                    tx       <= 1'b1;
                    baud_cnt <= '0;
                    if (pop) begin
                        bit_cnt <= '0;
                        state   <= ST_START;
                        tx      <= 1'b0;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        state <= ST_DATA;
                        tx    <= shift_reg[0];
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                            state   <= ST_PARITY;
                            tx      <= parity_bit;
`else
                            state   <= ST_STOP;
                            tx      <= 1'b1;
`endif
                        end else begin
                            bit_cnt   <= bit_cnt + 1'b1;
                            shift_reg <= shift_reg >> 1;
                            tx        <= shift_reg[1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (bit_end) begin
                        state <= ST_STOP;
                        tx    <= 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    if (bit_end) begin
                        if (bit_cnt == STOP_LAST) begin
                            bit_cnt <= '0;
                            if (pop) begin
                                state <= ST_START;
                                tx    <= 1'b0;
                            end else begin
                                state <= ST_IDLE;
                                tx    <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    tx    <= 1'b1;
                end
            endcase
            // Loading on pop covers both the IDLE and the back-to-back STOP entry.
            if (pop) begin
                shift_reg <= mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
                parity_bit <= parity_next;
`endif
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo. Writes to the main instance push the expected
// byte onto a queue. A monitor decodes every frame seen on tx and compares
// it with the popped entry. A second instance covers the narrow 5-bit,
// 2-stop-bit frame.
module tb_uart_tx_fifo;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int  PBIT    = 1;
    localparam bit  MAIN_ODD = 1'b0;
    localparam bit  NAR_ODD  = 1'b1;
`else
    localparam int  PBIT    = 0;
`endif
    localparam int NB_MAIN = 1 + 8 + PBIT + 1;
    localparam int NB_NAR  = 1 + 5 + PBIT + 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       m_sel = 1'b0, m_wr = 1'b0;
    logic [7:0] m_data = 8'h00;
    logic       m_tx, m_busy, m_full, m_empty, m_ovf;
    logic [2:0] m_count;

    logic       n_sel = 1'b0, n_wr = 1'b0;
    logic [7:0] n_data = 8'h00;
    logic       n_tx, n_busy, n_full, n_empty, n_ovf;
    logic [2:0] n_count;

    uart_tx_fifo #(
        .DATA_BITS(8), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(4), .STOP_BITS(1)
`ifdef UART_TX_PARITY_EN
        , .PARITY_ODD(int'(MAIN_ODD))
`endif
    ) u_main (
        .clk(clk), .rst(rst), .uart_sel(m_sel), .wr(m_wr), .data_in(m_data),
        .tx(m_tx), .busy(m_busy), .fifo_full(m_full), .fifo_empty(m_empty),
        .fifo_count(m_count), .overflow(m_ovf)
    );

    uart_tx_fifo #(
        .DATA_BITS(5), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(4), .STOP_BITS(2)
`ifdef UART_TX_PARITY_EN
        , .PARITY_ODD(int'(NAR_ODD))
`endif
    ) u_nar (
        .clk(clk), .rst(rst), .uart_sel(n_sel), .wr(n_wr), .data_in(n_data),
        .tx(n_tx), .busy(n_busy), .fifo_full(n_full), .fifo_empty(n_empty),
        .fifo_count(n_count), .overflow(n_ovf)
    );

    int errors = 0;
    int checks = 0;

    logic [7:0] exp_q[$];
    bit mon_en     = 1'b1;
    bit mon_active = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected frame bits, index 0 = start bit; unused upper bits stay 1.
    function automatic logic [11:0] mk_frame(input logic [7:0] d, input int db);
        logic [11:0] f;
        int k;
        f    = '1;
        f[0] = 1'b0;
        for (int i = 0; i < db; i++) begin
            f[1 + i] = d[i];
        end
        k = 1 + db;
`ifdef UART_TX_PARITY_EN
        begin
            logic p;
            p = (db == 5) ? NAR_ODD : MAIN_ODD;
            for (int i = 0; i < db; i++) begin
                p = p ^ d[i];
            end
            f[k] = p;
        end
`endif
        return f;
    endfunction

    // Scoreboard monitor: every sample of every bit must match, and busy must
    // stay high for the whole frame.
    initial begin
        logic [11:0] fb, cap;
        logic        glitch, unexp;
        logic [7:0]  d;
        forever begin
            @(negedge clk);
            if (mon_en && rst === 1'b1 && m_tx === 1'b0) begin
                mon_active = 1'b1;
                unexp = (exp_q.size() == 0);
                d = unexp ? 8'h00 : exp_q.pop_front();
                fb = mk_frame(d, 8);
                cap = '1;
                glitch = 1'b0;
                for (int s = 0; s < NB_MAIN * CPB; s++) begin
                    if (s > 0) @(negedge clk);
                    if (rst !== 1'b1) break;
                    if (s % CPB == 1) cap[s / CPB] = m_tx;
                    if (m_tx !== fb[s / CPB] || m_busy !== 1'b1) glitch = 1'b1;
                end
                if (unexp) check("unexpected_frame", 32'd1, 32'd0);
                else       check("frame", {19'd0, glitch, cap}, {19'd0, 1'b0, fb});
                mon_active = 1'b0;
            end
        end
    end

    task automatic put(input logic [7:0] b, input bit acc);
        @(negedge clk);
        m_sel  = 1'b1;
        m_wr   = 1'b1;
        m_data = b;
        if (acc) exp_q.push_back(b);
    endtask

    task automatic idle_bus;
        @(negedge clk);
        m_sel  = 1'b0;
        m_wr   = 1'b0;
        m_data = 8'h00;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (m_busy === 1'b1 && n < 1000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic wait_idle;
        int n;
        n = 0;
        while ((m_busy !== 1'b0 || m_empty !== 1'b1 || mon_active) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) check("wait_idle_timeout", 32'd1, 32'd0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int nb;
        logic [11:0] fb, cap;
        logic glitch;
        int bad;

        #1 rst = 1'b0;
        #2;
        check("rst_tx", m_tx, 1);
        check("rst_busy", m_busy, 0);
        check("rst_full", m_full, 0);
        check("rst_empty", m_empty, 1);
        check("rst_count", m_count, 0);
        check("rst_ovf", m_ovf, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // wr without select must not push
        m_wr = 1'b1;
        @(negedge clk);
        check("nosel_count", m_count, 0);
        check("nosel_busy", m_busy, 0);
        m_wr = 1'b0;

        // single byte 0xA5
        put(8'hA5, 1'b1);
        idle_bus;
        check("a5_pre_tx", m_tx, 1);
        check("a5_pre_count", m_count, 1);
        check("a5_pre_empty", m_empty, 0);
        @(negedge clk);
        check("a5_start_tx", m_tx, 0);
        check("a5_start_busy", m_busy, 1);
        check("a5_start_count", m_count, 0);
        count_busy(nb);
        check("a5_busy_cycles", nb, NB_MAIN * CPB);
        check("a5_idle_tx", m_tx, 1);
        wait_idle;

        // back-to-back 0x55, 0x0F
        put(8'h55, 1'b1);
        put(8'h0F, 1'b1);
        idle_bus;
        count_busy(nb);
        check("b2b_busy_cycles", nb, 2 * NB_MAIN * CPB);
        wait_idle;

        // parity frame 0x07
        put(8'h07, 1'b1);
        idle_bus;
        @(negedge clk);
        count_busy(nb);
        check("p07_busy_cycles", nb, NB_MAIN * CPB);
        wait_idle;

        // overflow: six pushes into a depth-4 FIFO, first pops after one cycle
        for (int i = 1; i <= 6; i++) begin
            put(8'(i), (i <= 5));
        end
        idle_bus;
        check("ovf_flag", m_ovf, 1);
        check("ovf_full", m_full, 1);
        check("ovf_count", m_count, 4);
        wait_idle;
        check("ovf_sticky", m_ovf, 1);

        // narrow frame on the second instance
        @(negedge clk);
        n_sel = 1'b1; n_wr = 1'b1; n_data = 8'hE0;
        @(negedge clk);
        n_sel = 1'b0; n_wr = 1'b0; n_data = 8'h00;
        check("nar_pre_tx", n_tx, 1);
        fb = mk_frame(8'hE0, 5);
        cap = '1;
        glitch = 1'b0;
        for (int s = 0; s < NB_NAR * CPB; s++) begin
            @(negedge clk);
            if (s % CPB == 1) cap[s / CPB] = n_tx;
            if (n_tx !== fb[s / CPB] || n_busy !== 1'b1) glitch = 1'b1;
        end
        check("nar_frame", {19'd0, glitch, cap}, {19'd0, 1'b0, fb});
        @(negedge clk);
        check("nar_end_busy", n_busy, 0);
        check("nar_end_tx", n_tx, 1);

        // reset during data bit 3 with two bytes queued
        mon_en = 1'b0;
        put(8'h00, 1'b0);
        put(8'h00, 1'b0);
        put(8'h00, 1'b0);
        idle_bus;
        repeat (16) @(posedge clk);
        #2;
        check("mid_tx_low", m_tx, 0);
        check("mid_count", m_count, 2);
        rst = 1'b0;
        #1;
        check("arst_tx", m_tx, 1);
        check("arst_busy", m_busy, 0);
        check("arst_count", m_count, 0);
        check("arst_empty", m_empty, 1);
        check("arst_ovf", m_ovf, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        bad = 0;
        repeat (60) begin
            @(negedge clk);
            if (m_tx !== 1'b1 || m_busy !== 1'b0) bad++;
        end
        check("post_rst_quiet", bad, 0);
        check("post_rst_count", m_count, 0);

        check("scoreboard_left", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
